// File: rtl/pong_pkg.sv
// pong_pkg: shared match-state encoding, serve directions and score width
package pong_pkg;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} match_state_t;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam int SCORE_W = 4;
endpackage

// File: rtl/pong_edge.sv
// pong_edge: ce-gated rising-edge detector
module pong_edge (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  // remember the level seen on the previous enabled cycle
  always_ff @(posedge clock)
    if (!reset) d_q <= 1'b0;
    else if (ce) d_q <= d_i;
  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/pong_match.sv
// pong_match: attract/serve/play/point/game-over sequencer with score keeping
module pong_match
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ce,
  input  logic               vsync,
  input  logic               start,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               serve,
  output logic               serve_dir,
  output logic               ball_en,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner
);
  localparam int CNT_W = $clog2((SERVE_FRAMES > POINT_FRAMES ? SERVE_FRAMES : POINT_FRAMES) + 1);
  localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  match_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic serve_q, serve_d, dir_q, dir_d, ben_q, ben_d;
  logic over_q, over_d, winner_q, winner_d, arm_q, arm_d;
  logic frame, cnt_last, at_win, new_match;
  pong_edge u_vsync_edge (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .d_i    (vsync),
    .rise_o (frame)
  );
  assign cnt_last = frame && cnt_q == CNT_W'(1);
  assign at_win = score1_q == WIN || score2_q == WIN;
  assign new_match = (state_q == IDLE || state_q == OVER) && state_d == SERVE;
  // match state register
  always_ff @(posedge clock)
    if (!reset) state_q <= IDLE;
    else if (ce) state_q <= state_d;
  // next match state; a simultaneous miss_l/miss_r still yields one point
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SERVE;
      SERVE:   if (cnt_last) state_d = PLAY;
      PLAY:    if (miss_l || miss_r) state_d = POINT;
      POINT:   if (cnt_last) state_d = at_win ? OVER : SERVE;
      OVER:    if (start && arm_q) state_d = SERVE;
      default: state_d = IDLE;
    endcase
  end
  // counter, scores and output next values derived from the transition taken
  always_comb begin
    cnt_d = (frame && (state_q == SERVE || state_q == POINT)) ? cnt_q - CNT_W'(1) : cnt_q;
    score1_d = new_match ? '0 : score1_q;
    score2_d = new_match ? '0 : score2_q;
    dir_d = (state_q == IDLE && state_d == SERVE) ? DIR_RIGHT : dir_q;
    if (state_d == SERVE && state_q != SERVE) cnt_d = SERVE_LD;
    if (state_q == PLAY && state_d == POINT) begin
      cnt_d = POINT_LD;
      if (miss_l) begin
        score2_d = score2_q + SCORE_W'(score2_q != WIN);
        dir_d = DIR_LEFT;
      end else begin
        score1_d = score1_q + SCORE_W'(score1_q != WIN);
        dir_d = DIR_RIGHT;
      end
    end
    winner_d = (state_d == OVER && state_q != OVER) ? score2_q == WIN : winner_q;
    serve_d = state_q == SERVE && state_d == PLAY;
    ben_d = state_d == PLAY;
    over_d = state_d == OVER;
    arm_d = state_q == OVER && (arm_q || !start);
  end
  // registered datapath and outputs
  always_ff @(posedge clock)
    if (!reset) begin
      cnt_q <= '0;
      score1_q <= '0;
      score2_q <= '0;
      serve_q <= 1'b0;
      dir_q <= DIR_RIGHT;
      ben_q <= 1'b0;
      over_q <= 1'b0;
      winner_q <= 1'b0;
      arm_q <= 1'b0;
    end else if (ce) begin
      cnt_q <= cnt_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      serve_q <= serve_d;
      dir_q <= dir_d;
      ben_q <= ben_d;
      over_q <= over_d;
      winner_q <= winner_d;
      arm_q <= arm_d;
    end
  assign serve = serve_q;
  assign serve_dir = dir_q;
  assign ball_en = ben_q;
  assign score1 = score1_q;
  assign score2 = score2_q;
  assign game_over = over_q;
  assign winner = winner_q;
endmodule

// File: tb/tb_pong_match.sv
// tb_pong_match: directed and random match play checked against a behavioural model
module tb_pong_match;
  localparam int W = 3;
  localparam int SF = 2;
  localparam int PF = 2;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;
  logic clk = 1'b0;
  logic reset = 1'b0, ce = 1'b0, vsync = 1'b0, start = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic serve, serve_dir, ball_en, game_over, winner;
  logic [3:0] score1, score2;
  int n_chk = 0, n_err = 0;
  int m_ph = M_IDLE, m_ticks = 0, m_s1 = 0, m_s2 = 0;
  bit m_vs = 0, m_serve = 0, m_dir = 1, m_ben = 0, m_go = 0, m_win = 0, m_low = 0;

  pong_match #(.WIN_SCORE(W), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
    .clock(clk), .reset(reset), .ce(ce), .vsync(vsync), .start(start),
    .miss_l(miss_l), .miss_r(miss_r), .serve(serve), .serve_dir(serve_dir),
    .ball_en(ball_en), .score1(score1), .score2(score2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic begin_match();
    m_ph = M_SERVE;
    m_ticks = 0;
    m_s1 = 0;
    m_s2 = 0;
  endtask

  task automatic model_edge(input bit c, vs, st, ml, mr, rs);
    bit tick;
    if (!rs) begin
      m_ph = M_IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_vs = 0;
      m_serve = 0; m_dir = 1; m_ben = 0; m_go = 0; m_win = 0; m_low = 0;
      return;
    end
    if (!c) return;
    tick = vs && !m_vs;
    m_vs = vs;
    m_serve = 0;
    case (m_ph)
      M_IDLE: if (st) begin begin_match(); m_dir = 1; end
      M_SERVE: if (tick) begin
        m_ticks++;
        if (m_ticks == SF) begin m_ph = M_PLAY; m_serve = 1; end
      end
      M_PLAY: if (ml || mr) begin
        if (ml) begin m_s2 = m_s2 < W ? m_s2 + 1 : W; m_dir = 0; end
        else begin m_s1 = m_s1 < W ? m_s1 + 1 : W; m_dir = 1; end
        m_ph = M_POINT;
        m_ticks = 0;
      end
      M_POINT: if (tick) begin
        m_ticks++;
        if (m_ticks == PF) begin
          if (m_s1 == W || m_s2 == W) begin m_ph = M_OVER; m_win = m_s2 == W; m_low = 0; end
          else begin m_ph = M_SERVE; m_ticks = 0; end
        end
      end
      default: if (st && m_low) begin_match(); else if (!st) m_low = 1;
    endcase
    m_ben = m_ph == M_PLAY;
    m_go = m_ph == M_OVER;
  endtask

  task automatic cyc(input bit c, vs, st, ml, mr, rs);
    @(negedge clk);
    ce = c; vsync = vs; start = st; miss_l = ml; miss_r = mr; reset = rs;
    model_edge(c, vs, st, ml, mr, rs);
    @(posedge clk);
    #1;
    chk("serve", serve, m_serve);
    chk("serve_dir", serve_dir, m_dir);
    chk("ball_en", ball_en, m_ben);
    chk("score1", score1, 8'(m_s1));
    chk("score2", score2, 8'(m_s2));
    chk("game_over", game_over, m_go);
    if (m_go) chk("winner", winner, m_win);
  endtask

  task automatic ce_period(input bit vs, st, ml, mr);
    cyc(1, vs, st, ml, mr, 1);
    repeat (7) cyc(0, vs, st, ml, mr, 1);
  endtask

  task automatic tick_n(input int n, input bit st);
    repeat (n) begin
      ce_period(1, st, 0, 0);
      ce_period(0, st, 0, 0);
    end
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    tick_n(5, 0);
    chk("idle_ball_en", ball_en, 0);
    chk("idle_scores", {score1, score2}, 0);
    ce_period(0, 1, 0, 0);
    tick_n(1, 0);
    chk("pre_serve", serve, 0);
    ce_period(1, 0, 0, 0);
    chk("serve_pulse", serve, 1);
    chk("serve_dir_r", serve_dir, 1);
    chk("play_ball_en", ball_en, 1);
    ce_period(0, 0, 0, 0);
    chk("serve_drop", serve, 0);
    ce_period(0, 0, 0, 1);
    chk("miss_r_score1", score1, 1);
    chk("miss_r_ball_en", ball_en, 0);
    tick_n(3, 0);
    ce_period(1, 0, 0, 0);
    chk("reserve_pulse", serve, 1);
    chk("reserve_dir", serve_dir, 1);
    ce_period(0, 0, 0, 0);
    ce_period(0, 0, 1, 1);
    chk("both_score2", score2, 1);
    chk("both_score1", score1, 1);
    chk("both_dir", serve_dir, 0);
    tick_n(4, 0);
    ce_period(0, 0, 1, 0);
    tick_n(4, 0);
    ce_period(0, 1, 1, 0);
    chk("win_score2", score2, 3);
    tick_n(2, 1);
    chk("over_flag", game_over, 1);
    chk("over_winner", winner, 1);
    ce_period(0, 1, 0, 0);
    ce_period(0, 1, 0, 0);
    chk("held_start_ignored", game_over, 1);
    ce_period(0, 0, 0, 0);
    ce_period(0, 1, 0, 0);
    chk("restart_over", game_over, 0);
    chk("restart_scores", {score1, score2}, 0);
    chk("restart_dir", serve_dir, 0);
    tick_n(2, 0);
    ce_period(0, 0, 0, 1);
    tick_n(4, 0);
    ce_period(0, 0, 0, 1);
    tick_n(4, 0);
    ce_period(0, 0, 1, 0);
    chk("point_scores", {score1, score2}, 8'h21);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_scores", {score1, score2}, 0);
    chk("rst_ball_en", ball_en, 0);
    chk("rst_dir", serve_dir, 1);
    chk("rst_over", game_over, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) cyc(0, 0, 0, 0, 0, 0);
      ce_period($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
